// File: rtl/case_class_sequencer_if.sv
// Operand/result handshake bundle for case_class_sequencer.
// The master is the producer/consumer side; the slave is the sequencer.
interface case_class_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] val1;
  logic [2:0] val2;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] result;
  logic       hold;

  modport master (
    output in_valid, val1, val2, out_ready,
    input  in_ready, out_valid, result, hold
  );

  modport slave (
    input  in_valid, val1, val2, out_ready,
    output in_ready, out_valid, result, hold
  );
endinterface

// File: rtl/case_class_sequencer.sv
// Burst sequencer around a masked 3-bit label classifier with saturating per-class hit counters.
// Define CASE_SEQ_DEFAULT_EN to give the decode a default arm (010/011 -> class 3, no hold).
module case_class_sequencer #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned BURST = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  case_class_sequencer_if.slave bus,
  output logic [CNT_W-1:0]      cnt0,
  output logic [CNT_W-1:0]      cnt1,
  output logic [CNT_W-1:0]      cnt2,
  output logic                  done
);

  typedef enum logic [2:0] {StIdle, StAccept, StClassify, StEmit, StDone} state_e;

  localparam logic [7:0] LastIdx = 8'(BURST - 1);

  state_e           state_q, state_d;
  logic [2:0]       masked_q, masked_d;
  logic [7:0]       idx_q, idx_d;
  logic [1:0]       result_q, result_d;
  logic             hold_q, hold_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  logic             busy_q, in_ready_q, out_valid_q, done_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == '1) ? x : x + CNT_W'(1);
  endfunction

  always_comb begin
    state_d  = state_q;
    masked_d = masked_q;
    idx_d    = idx_q;
    result_d = result_q;
    hold_d   = hold_q;
    cnt0_d   = cnt0_q;
    cnt1_d   = cnt1_q;
    cnt2_d   = cnt2_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StAccept;
          idx_d   = '0;
          cnt0_d  = '0;
          cnt1_d  = '0;
          cnt2_d  = '0;
        end
      end
      StAccept: begin
        if (bus.in_valid && in_ready_q) begin
          masked_d = bus.val1 & bus.val2;
          state_d  = StClassify;
        end
      end
      StClassify: begin
        state_d = StEmit;
        case (masked_q)
          3'b000, 3'b001: begin
            result_d = 2'd0;
            hold_d   = 1'b0;
            cnt0_d   = sat_inc(cnt0_q);
          end
          3'b101: begin
            result_d = 2'd1;
            hold_d   = 1'b0;
            cnt1_d   = sat_inc(cnt1_q);
          end
          3'b100, 3'b110, 3'b111: begin
            result_d = 2'd2;
            hold_d   = 1'b0;
            cnt2_d   = sat_inc(cnt2_q);
          end
`ifdef CASE_SEQ_DEFAULT_EN
          default: begin
            result_d = 2'd3;
            hold_d   = 1'b0;
          end
`else
          // Unlisted labels keep the previous class and flag it.
          3'b010, 3'b011: begin
            hold_d = 1'b1;
          end
`endif
        endcase
      end
      StEmit: begin
        if (out_valid_q && bus.out_ready) begin
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = StAccept;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Status outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      masked_q    <= 3'b000;
      idx_q       <= '0;
      result_q    <= '0;
      hold_q      <= 1'b0;
      cnt0_q      <= '0;
      cnt1_q      <= '0;
      cnt2_q      <= '0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      masked_q    <= masked_d;
      idx_q       <= idx_d;
      result_q    <= result_d;
      hold_q      <= hold_d;
      cnt0_q      <= cnt0_d;
      cnt1_q      <= cnt1_d;
      cnt2_q      <= cnt2_d;
      busy_q      <= (state_d != StIdle);
      in_ready_q  <= (state_d == StAccept);
      out_valid_q <= (state_d == StEmit);
      done_q      <= (state_d == StDone);
    end
  end

  assign busy          = busy_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.hold      = hold_q;
  assign cnt0          = cnt0_q;
  assign cnt1          = cnt1_q;
  assign cnt2          = cnt2_q;
  assign done          = done_q;

endmodule
